// File: rtl/load_store_unit.sv
// Load/store unit: turns byte/half/word CPU accesses into word-aligned memory
// cycles on a big-endian word memory; sub-word stores are read-modify-write.

module lsu_lane (
  input  logic [7:0] mem,
  input  logic [7:0] wbyte,
  input  logic       en,
  output logic [7:0] merged
);
  assign merged = en ? wbyte : mem;
endmodule

module load_store_unit #(
  parameter int MEM_WAIT = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req,
  input  logic        is_write,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] rdata,
  output logic        error,
  output logic        MemoryRead,
  output logic        MemoryWrite,
  output logic [31:0] Address,
  output logic [31:0] InputData,
  input  logic [31:0] OutputData
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  state_t      st_q, st_d;
  logic        wr_q, sext_q, err_q;
  logic [1:0]  size_q, off_q;
  logic [29:0] waddr_q;
  logic [31:0] wword_q, rdata_q;
  logic [3:0]  cnt_q;
  logic        bad;

  assign bad = (size == 2'b11) || (size == 2'b01 && addr[0]) ||
               (size == 2'b10 && addr[1:0] != 2'b00);

  always_ff @(posedge clock) begin
    if (reset) st_q <= IDLE;
    else       st_q <= st_d;
  end

  always_comb begin
    st_d = st_q;
    case (st_q)
      IDLE:  if (req) begin
               if (bad)                          st_d = DONE;
               else if (is_write && size == 2'b10) st_d = WRITE;
               else                              st_d = READ;
             end
      READ:  if (cnt_q == 4'd0) st_d = wr_q ? WRITE : DONE;
      WRITE: st_d = DONE;
      DONE:  st_d = IDLE;
      default: st_d = IDLE;
    endcase
  end

  // Byte lanes in word order: lane i is bits [8i+7:8i], so offset k maps to lane ~k.
  logic [3:0][7:0] mem_lanes, wr_lanes, merged;
  logic [3:0]      lane_en;

  assign mem_lanes = OutputData;
  assign wr_lanes  = (size_q == 2'b00) ? {4{wword_q[7:0]}} : {2{wword_q[15:0]}};

  for (genvar g = 0; g < 4; g++) begin : g_lane
    localparam logic [1:0] LI = 2'(g);
    assign lane_en[g] = (size_q == 2'b00) ? (LI == ~off_q) :
                        (size_q == 2'b01) ? (LI[1] == ~off_q[1]) : 1'b1;
    lsu_lane u_lane (
      .mem    (mem_lanes[g]),
      .wbyte  (wr_lanes[g]),
      .en     (lane_en[g]),
      .merged (merged[g])
    );
  end

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_val;

  always_comb begin
    ld_byte = 8'(OutputData >> {~off_q, 3'b000});
    ld_half = 16'(OutputData >> {~off_q[1], 4'b0000});
    case (size_q)
      2'b00:   ld_val = sext_q ? {{24{ld_byte[7]}}, ld_byte} : {24'b0, ld_byte};
      2'b01:   ld_val = sext_q ? {{16{ld_half[15]}}, ld_half} : {16'b0, ld_half};
      default: ld_val = OutputData;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_q    <= 1'b0;
      sext_q  <= 1'b0;
      err_q   <= 1'b0;
      size_q  <= 2'b00;
      off_q   <= 2'b00;
      waddr_q <= '0;
      wword_q <= '0;
      rdata_q <= '0;
      cnt_q   <= '0;
    end else begin
      case (st_q)
        IDLE: if (req) begin
          wr_q    <= is_write;
          sext_q  <= sign_ext;
          err_q   <= bad;
          size_q  <= size;
          off_q   <= addr[1:0];
          waddr_q <= addr[31:2];
          wword_q <= wdata;
          cnt_q   <= 4'(MEM_WAIT - 1);
        end
        READ: begin
          if (cnt_q == 4'd0) begin
            if (wr_q) wword_q <= merged;
            else      rdata_q <= ld_val;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy        = (st_q == READ) || (st_q == WRITE);
  assign done        = (st_q == DONE);
  assign error       = done & err_q;
  assign rdata       = rdata_q;
  assign MemoryRead  = (st_q == READ);
  assign MemoryWrite = (st_q == WRITE);
  assign Address     = (MemoryRead || MemoryWrite) ? {waddr_q, 2'b00} : 32'h0;
  assign InputData   = MemoryWrite ? wword_q : 32'h0;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: byte-array memory, byte-level reference model,
// directed spec examples plus randomized accesses with input jitter while busy.

module tb_load_store_unit;
  localparam int MW = 1;

  logic        clock = 1'b0;
  logic        reset, req, is_write, sign_ext, mem_init;
  logic [1:0]  size;
  logic [31:0] addr, wdata;
  logic        busy, done, error, MemoryRead, MemoryWrite;
  logic [31:0] rdata, Address, InputData, OutputData;

  int checks = 0;
  int errors = 0;

  load_store_unit #(.MEM_WAIT(MW)) dut (
    .clock(clock), .reset(reset), .req(req), .is_write(is_write), .size(size),
    .sign_ext(sign_ext), .addr(addr), .wdata(wdata), .busy(busy), .done(done),
    .rdata(rdata), .error(error), .MemoryRead(MemoryRead), .MemoryWrite(MemoryWrite),
    .Address(Address), .InputData(InputData), .OutputData(OutputData)
  );

  always #5 clock = ~clock;

  function automatic logic [7:0] init_byte(int i);
    case (i)
      16: return 8'h80;
      17: return 8'h12;
      18: return 8'h34;
      19: return 8'hFF;
      default: return 8'(i * 37 + 5);
    endcase
  endfunction

  // Memory seen by the DUT
  logic [7:0] mem [256];
  logic [7:0] ab;
  assign ab = {Address[7:2], 2'b00};
  assign OutputData = {mem[ab], mem[ab + 8'd1], mem[ab + 8'd2], mem[ab + 8'd3]};

  always @(posedge clock) begin
    if (mem_init) for (int i = 0; i < 256; i++) mem[i] <= init_byte(i);
    else if (MemoryWrite)
      for (int i = 0; i < 4; i++) mem[8'(Address[7:0] + i)] <= InputData[31 - 8*i -: 8];
  end

  // Bus monitor
  int rd_cnt = 0, wr_cnt = 0, proto_bad = 0;
  logic [31:0] last_raddr = 0, last_waddr = 0, last_wdata = 0;
  always @(negedge clock) begin
    if (MemoryRead) begin rd_cnt <= rd_cnt + 1; last_raddr <= Address; end
    if (MemoryWrite) begin
      wr_cnt <= wr_cnt + 1; last_waddr <= Address; last_wdata <= InputData;
    end
    if ((MemoryRead && MemoryWrite) ||
        ((MemoryRead || MemoryWrite) && Address[1:0] != 2'b00) ||
        (!MemoryRead && !MemoryWrite && (Address != 0 || InputData != 0)))
      proto_bad <= proto_bad + 1;
  end

  // Reference model: byte-addressed big-endian memory
  logic [7:0]  ref_mem [256];
  logic [31:0] exp_rdata;

  task automatic do_access(input logic w, input logic [1:0] sz, input logic sx,
                           input logic [31:0] a, input logic [31:0] wd, input bit jitter);
    int lat, exp_lat, rd0, wr0, pb0, n, exp_rd, exp_wr;
    logic bad;
    logic [31:0] v, al, exp_word;
    bad = (sz == 2'b11) || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00);
    n = 1 << sz;
    al = {a[31:2], 2'b00};
    exp_lat = bad ? 1 : !w ? MW + 1 : (sz == 2'b10) ? 2 : MW + 2;
    exp_rd  = (bad || (w && sz == 2'b10)) ? 0 : MW;
    exp_wr  = (!bad && w) ? 1 : 0;
    @(negedge clock);
    req = 1'b1; is_write = w; size = sz; sign_ext = sx; addr = a; wdata = wd;
    rd0 = rd_cnt; wr0 = wr_cnt; pb0 = proto_bad;
    @(posedge clock); #1;
    lat = 1; req = 1'b0;
    while (done !== 1'b1 && lat < 50) begin
      if (jitter) begin
        req = 1'($urandom); is_write = 1'($urandom); size = 2'($urandom);
        sign_ext = 1'($urandom); addr = $urandom; wdata = $urandom;
      end
      @(posedge clock); #1;
      lat++;
    end
    req = 1'b0;
    if (!bad && !w) begin
      v = 0;
      for (int i = 0; i < n; i++) v = (v << 8) | 32'(ref_mem[a[7:0] + i]);
      if (n == 1) v = sx ? {{24{v[7]}}, v[7:0]} : {24'b0, v[7:0]};
      if (n == 2) v = sx ? {{16{v[15]}}, v[15:0]} : {16'b0, v[15:0]};
      exp_rdata = v;
    end
    if (!bad && w)
      for (int i = 0; i < n; i++) ref_mem[a[7:0] + i] = 8'(wd >> (8 * (n - 1 - i)));
    exp_word = {ref_mem[al[7:0]], ref_mem[al[7:0] + 1], ref_mem[al[7:0] + 2], ref_mem[al[7:0] + 3]};

    checks++; if (lat !== exp_lat) begin errors++;
      $display("FAIL latency a=%h sz=%0d w=%0b got %0d exp %0d", a, sz, w, lat, exp_lat); end
    checks++; if (error !== bad) begin errors++;
      $display("FAIL error a=%h sz=%0d got %b exp %b", a, sz, error, bad); end
    checks++; if (busy !== 1'b0) begin errors++;
      $display("FAIL busy_at_done got %b exp 0", busy); end
    checks++; if (rdata !== exp_rdata) begin errors++;
      $display("FAIL rdata a=%h sz=%0d sx=%0b got %h exp %h", a, sz, sx, rdata, exp_rdata); end
    checks++; if (rd_cnt - rd0 != exp_rd) begin errors++;
      $display("FAIL read_cycles got %0d exp %0d", rd_cnt - rd0, exp_rd); end
    checks++; if (wr_cnt - wr0 != exp_wr) begin errors++;
      $display("FAIL write_cycles got %0d exp %0d", wr_cnt - wr0, exp_wr); end
    checks++; if (proto_bad != pb0) begin errors++;
      $display("FAIL bus_protocol violations got %0d exp 0", proto_bad - pb0); end
    if (exp_rd > 0) begin
      checks++; if (last_raddr !== al) begin errors++;
        $display("FAIL read_addr got %h exp %h", last_raddr, al); end
    end
    if (exp_wr > 0) begin
      checks++; if (last_waddr !== al || last_wdata !== exp_word) begin errors++;
        $display("FAIL write_bus got %h/%h exp %h/%h", last_waddr, last_wdata, al, exp_word); end
    end
    @(posedge clock); #1;
    checks++; if (done !== 1'b0) begin errors++;
      $display("FAIL done_pulse_width got %b exp 0", done); end
  endtask

  task automatic check_idle_outputs(input string tag);
    checks++;
    if ({busy, done, error, MemoryRead, MemoryWrite} !== 5'b0 || rdata !== 0 ||
        Address !== 0 || InputData !== 0) begin
      errors++;
      $display("FAIL %s outputs got b%b d%b e%b r%b w%b rd=%h A=%h I=%h exp all 0",
               tag, busy, done, error, MemoryRead, MemoryWrite, rdata, Address, InputData);
    end
  endtask

  task automatic test_reset();
    @(negedge clock);
    req = 1'b1; is_write = 1'b0; size = 2'b10; addr = 32'h10;
    @(posedge clock); #1;
    check_idle_outputs("reset_with_req");
    @(posedge clock); #1;
    check_idle_outputs("reset_hold");
    @(negedge clock);
    req = 1'b0; reset = 1'b0; mem_init = 1'b0;
    exp_rdata = 0;
  endtask

  task automatic test_spec_examples();
    do_access(1'b0, 2'b00, 1'b1, 32'h10, 32'h0, 1'b0);
    checks++; if (rdata !== 32'hFFFFFF80) begin errors++;
      $display("FAIL lb_0x10 got %h exp FFFFFF80", rdata); end
    do_access(1'b0, 2'b01, 1'b0, 32'h12, 32'h0, 1'b0);
    checks++; if (rdata !== 32'h000034FF) begin errors++;
      $display("FAIL lhu_0x12 got %h exp 000034FF", rdata); end
    do_access(1'b0, 2'b01, 1'b1, 32'h10, 32'h0, 1'b0);
    checks++; if (rdata !== 32'hFFFF8012) begin errors++;
      $display("FAIL lh_0x10 got %h exp FFFF8012", rdata); end
  endtask

  task automatic test_req_held();
    int rd0, cyc;
    @(negedge clock);
    req = 1'b1; is_write = 1'b0; size = 2'b10; sign_ext = 1'b0; addr = 32'h10;
    rd0 = rd_cnt; cyc = 0;
    @(posedge clock); #1;
    while (done !== 1'b1 && cyc < 50) begin @(posedge clock); #1; cyc++; end
    exp_rdata = 32'h801234FF;
    checks++; if (rdata !== 32'h801234FF || rd_cnt - rd0 != MW) begin errors++;
      $display("FAIL lw_held got %h/%0d reads exp 801234FF/%0d", rdata, rd_cnt - rd0, MW); end
    @(posedge clock); #1;
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++;
      $display("FAIL held_back_to_idle got busy %b done %b exp 0 0", busy, done); end
    @(posedge clock); #1;
    checks++; if (busy !== 1'b1) begin errors++;
      $display("FAIL held_restart got busy %b exp 1", busy); end
    req = 1'b0; cyc = 0;
    while (done !== 1'b1 && cyc < 50) begin @(posedge clock); #1; cyc++; end
    checks++; if (done !== 1'b1 || rd_cnt - rd0 != 2 * MW) begin errors++;
      $display("FAIL held_second_access got done %b reads %0d exp 1/%0d", done, rd_cnt - rd0, 2 * MW); end
    @(posedge clock); #1;
  endtask

  task automatic test_store_examples();
    do_access(1'b1, 2'b00, 1'b0, 32'h11, 32'h000000AB, 1'b0);
    checks++; if (last_wdata !== 32'h80AB34FF || last_waddr !== 32'h10) begin errors++;
      $display("FAIL sb_0x11 got %h@%h exp 80AB34FF@00000010", last_wdata, last_waddr); end
    do_access(1'b1, 2'b10, 1'b0, 32'h12, 32'h12345678, 1'b0);
    do_access(1'b1, 2'b10, 1'b0, 32'h20, 32'hCAFEF00D, 1'b0);
    do_access(1'b1, 2'b01, 1'b0, 32'h22, 32'h0000BEEF, 1'b0);
    do_access(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 1'b0);
    do_access(1'b0, 2'b11, 1'b0, 32'h20, 32'h0, 1'b0);
    do_access(1'b0, 2'b01, 1'b1, 32'h21, 32'h0, 1'b0);
  endtask

  task automatic test_reset_abort();
    int wr0;
    @(negedge clock);
    req = 1'b1; is_write = 1'b1; size = 2'b01; sign_ext = 1'b0; addr = 32'h10; wdata = 32'h5A5A;
    wr0 = wr_cnt;
    @(posedge clock); #1;
    req = 1'b0;
    checks++; if (MemoryRead !== 1'b1 || busy !== 1'b1) begin errors++;
      $display("FAIL abort_in_read got rd %b busy %b exp 1 1", MemoryRead, busy); end
    reset = 1'b1;
    @(posedge clock); #1;
    check_idle_outputs("abort_reset");
    reset = 1'b0; exp_rdata = 0;
    repeat (4) @(posedge clock);
    #1;
    checks++; if (wr_cnt != wr0) begin errors++;
      $display("FAIL abort_no_write got %0d writes exp 0", wr_cnt - wr0); end
    for (int i = 16; i < 20; i++) begin
      checks++; if (mem[i] !== ref_mem[i]) begin errors++;
        $display("FAIL abort_mem[%0d] got %h exp %h", i, mem[i], ref_mem[i]); end
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 300; k++)
      do_access(1'($urandom), 2'($urandom), 1'($urandom), 32'($urandom_range(0, 252)),
                $urandom, 1'b1);
  endtask

  task automatic test_memory();
    for (int i = 0; i < 256; i++) begin
      checks++; if (mem[i] !== ref_mem[i]) begin errors++;
        $display("FAIL mem[%0d] got %h exp %h", i, mem[i], ref_mem[i]); end
    end
  endtask

  initial begin
    reset = 1'b1; mem_init = 1'b1; req = 1'b0; is_write = 1'b0; size = 2'b00;
    sign_ext = 1'b0; addr = 0; wdata = 0; exp_rdata = 0;
    for (int i = 0; i < 256; i++) ref_mem[i] = init_byte(i);
    repeat (2) @(posedge clock);
    test_reset();
    test_spec_examples();
    test_req_held();
    test_store_examples();
    test_reset_abort();
    test_random();
    test_memory();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
